// File: rtl/lighting_pkg.sv
// rtl/lighting_pkg.sv - shared colour constants, FSM states and colour helpers for lighting_ctrl
package lighting_pkg;

    localparam logic [2:0] COLOUR_MIN = 3'b001;
    localparam logic [2:0] COLOUR_MAX = 3'b110;
    localparam logic [2:0] STEP_LIMIT = 3'd6;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        STEP,
        VERIFY,
        AUTO
    } state_t;

    function automatic logic [2:0] next_colour(input logic [2:0] c);
        return (c == COLOUR_MAX) ? COLOUR_MIN : c + 3'd1;
    endfunction

    function automatic logic colour_legal(input logic [2:0] c);
        return (c >= COLOUR_MIN) && (c <= COLOUR_MAX);
    endfunction

endpackage

// File: rtl/lighting_ctrl_if.sv
// rtl/lighting_ctrl_if.sv - colour request handshake between requester and lighting_ctrl
interface lighting_ctrl_if;

    logic       req_valid;
    logic [2:0] req_colour;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_colour,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_colour,
        output req_ready
    );

endinterface

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - idle dwell counter with terminal-count flag; a dwell of 0 behaves as 1
module dwell_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_dwell,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_last;

    assign w_last = (i_dwell == '0) ? '0 : i_dwell - W'(1);
    // >= keeps the counter from running away if dwell is lowered mid-count
    assign o_tc   = (r_cnt >= w_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc ? '0 : r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/lighting_ctrl.sv
// rtl/lighting_ctrl.sv - steps the lighting block's button until its colour matches the request
module lighting_ctrl
    import lighting_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    lighting_ctrl_if.slave     req,
    input  logic               i_auto_en,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [2:0]         i_colour_in,
    output logic               o_button,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_req_err,
    output logic               o_fault
);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_target, w_target_nxt;
    logic [2:0] r_prev, w_prev_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_auto, w_auto_nxt;
    logic       r_fault, w_fault_nxt;
    logic       r_button, w_button_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_done, w_done_nxt;
    logic       r_req_err, w_err_nxt;
    logic       r_req_ready, w_ready_nxt;

    logic w_accept, w_dwell_en, w_dwell_clr, w_dwell_tc, w_auto_fire;
    logic w_hit, w_bad;

    assign w_accept    = req.req_valid & r_req_ready;
    assign w_dwell_en  = (r_state == IDLE) & i_auto_en & ~r_fault;
    assign w_dwell_clr = ~i_auto_en | w_accept;
    assign w_auto_fire = w_dwell_en & w_dwell_tc;
    assign w_hit       = (i_colour_in == r_target);
    assign w_bad       = (i_colour_in != next_colour(r_prev)) | ~colour_legal(i_colour_in);

    dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_dwell_en),
        .i_clr   (w_dwell_clr),
        .i_dwell (i_dwell),
        .o_tc    (w_dwell_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_target    <= COLOUR_MIN;
            r_prev      <= COLOUR_MIN;
            r_cnt       <= '0;
            r_auto      <= 1'b0;
            r_fault     <= 1'b0;
            r_button    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_req_err   <= 1'b0;
            r_req_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_target    <= w_target_nxt;
            r_prev      <= w_prev_nxt;
            r_cnt       <= w_cnt_nxt;
            r_auto      <= w_auto_nxt;
            r_fault     <= w_fault_nxt;
            r_button    <= w_button_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_req_err   <= w_err_nxt;
            r_req_ready <= w_ready_nxt;
        end
    end

    // VERIFY folds the CHECK decision in so each step costs two cycles
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_prev_nxt   = r_prev;
        w_cnt_nxt    = r_cnt;
        w_auto_nxt   = r_auto;
        w_fault_nxt  = r_fault;
        w_button_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (colour_legal(req.req_colour)) begin
                        w_target_nxt = req.req_colour;
                        w_cnt_nxt    = '0;
                        w_auto_nxt   = 1'b0;
                        w_state_nxt  = CHECK;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_auto_fire) begin
                    w_auto_nxt   = 1'b1;
                    w_button_nxt = 1'b1;
                    w_state_nxt  = AUTO;
                end
            end
            CHECK: begin
                if (w_hit) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == STEP_LIMIT) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_button_nxt = 1'b1;
                    w_state_nxt  = STEP;
                end
            end
            STEP: begin
                w_prev_nxt  = i_colour_in;
                w_cnt_nxt   = r_cnt + 3'd1;
                w_state_nxt = VERIFY;
            end
            AUTO: begin
                w_prev_nxt  = i_colour_in;
                w_state_nxt = VERIFY;
            end
            VERIFY: begin
                if (w_bad) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_auto) begin
                    w_state_nxt = IDLE;
                end else if (w_hit) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_cnt == STEP_LIMIT) begin
                    w_fault_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_button_nxt = 1'b1;
                    w_state_nxt  = STEP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_ready_nxt = (w_state_nxt == IDLE) && !w_fault_nxt;
        w_busy_nxt  = (w_state_nxt == CHECK) || (w_state_nxt == STEP) ||
                      ((w_state_nxt == VERIFY) && !w_auto_nxt);
    end

    assign req.req_ready = r_req_ready;
    assign o_button      = r_button;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_req_err     = r_req_err;
    assign o_fault       = r_fault;

endmodule
